// File: rtl/svl_line_decoder.sv
// Log line decoder: parses "<mod>: <LEVEL>: (@ <t>) <text>\n" from a byte stream,
// filters by verbosity and presents one event per line.
module svl_line_decoder #(
  parameter int VERBOSITY = 2,
  parameter int TS_WIDTH  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [2:0]          evt_level,
  output logic [TS_WIDTH-1:0] evt_time,
  output logic                evt_time_ovf,
  output logic [15:0]         line_count,
  output logic [15:0]         drop_count
);

  localparam int TW = TS_WIDTH + 4;

  typedef enum logic [3:0] {
    S_MODNAME, S_SP1, S_LEVEL, S_SP2, S_OPEN,
    S_AT, S_SP3, S_DIGITS, S_TEXT, S_EMIT
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          lvl_q, lvl_d;
  logic                ok_q, ok_d;
  logic [TS_WIDTH-1:0] time_q, time_d;
  logic                ovf_q, ovf_d;
  logic                ndig_q, ndig_d;
  logic [63:0]         lbuf_q, lbuf_d;
  logic [3:0]          lcnt_q, lcnt_d;
  logic                evt_valid_q, evt_valid_d;
  logic [2:0]          evt_level_q, evt_level_d;
  logic [TS_WIDTH-1:0] evt_time_q, evt_time_d;
  logic                evt_ovf_q, evt_ovf_d;
  logic [15:0]         line_cnt_q, line_cnt_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;

  logic                take;
  logic                is_digit;
  logic [TW-1:0]       t_ext;
  logic [2:0]          tok_lvl;
  logic [2:0]          fin_lvl;
  logic                pass;

  assign in_ready     = !(evt_valid_q && !evt_ready);
  assign evt_valid    = evt_valid_q;
  assign evt_level    = evt_level_q;
  assign evt_time     = evt_time_q;
  assign evt_time_ovf = evt_ovf_q;
  assign line_count   = line_cnt_q;
  assign drop_count   = drop_cnt_q;

  assign take     = in_valid && in_ready && (in_data != 8'h0D);
  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign t_ext    = TW'(time_q) * TW'(10) + TW'(in_data[3:0]);
  assign fin_lvl  = ok_q ? lvl_q : 3'd0;
  assign pass     = (fin_lvl == 3'd0) ||
                    ((VERBOSITY != 0) && (int'(fin_lvl) >= VERBOSITY));

  // token is right-aligned in lbuf, length lcnt
  always_comb begin
    tok_lvl = 3'd0;
    unique case (1'b1)
      (lcnt_q == 4'd5) && (lbuf_q[39:0] == "DEBUG"):    tok_lvl = 3'd1;
      (lcnt_q == 4'd4) && (lbuf_q[31:0] == "INFO"):     tok_lvl = 3'd2;
      (lcnt_q == 4'd7) && (lbuf_q[55:0] == "WARNING"):  tok_lvl = 3'd3;
      (lcnt_q == 4'd8) && (lbuf_q[63:0] == "CRITICAL"): tok_lvl = 3'd4;
      (lcnt_q == 4'd5) && (lbuf_q[39:0] == "ERROR"):    tok_lvl = 3'd5;
      default:                                           tok_lvl = 3'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    lvl_d       = lvl_q;
    ok_d        = ok_q;
    time_d      = time_q;
    ovf_d       = ovf_q;
    ndig_d      = ndig_q;
    lbuf_d      = lbuf_q;
    lcnt_d      = lcnt_q;
    evt_valid_d = evt_valid_q && !evt_ready;
    evt_level_d = evt_level_q;
    evt_time_d  = evt_time_q;
    evt_ovf_d   = evt_ovf_q;
    line_cnt_d  = line_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    if (take && (in_data == 8'h0A)) begin
      if (line_cnt_q != 16'hFFFF) line_cnt_d = line_cnt_q + 16'd1;
      if (pass) begin
        evt_valid_d = 1'b1;
        evt_level_d = fin_lvl;
        evt_time_d  = ok_q ? time_q : '0;
        evt_ovf_d   = ok_q && ovf_q;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
      lvl_d   = 3'd0;
      ok_d    = 1'b0;
      time_d  = '0;
      ovf_d   = 1'b0;
      ndig_d  = 1'b0;
      lbuf_d  = '0;
      lcnt_d  = 4'd0;
      state_d = S_EMIT;
    end else if (take) begin
      unique case (state_q)
        S_MODNAME, S_EMIT: begin
          state_d = (in_data == ":") ? S_SP1 : S_MODNAME;
        end
        S_SP1: state_d = (in_data == " ") ? S_LEVEL : S_TEXT;
        S_LEVEL: begin
          if (in_data == ":") begin
            lvl_d   = tok_lvl;
            state_d = (tok_lvl != 3'd0) ? S_SP2 : S_TEXT;
          end else if (lcnt_q == 4'd8) begin
            state_d = S_TEXT;
          end else begin
            lbuf_d = {lbuf_q[55:0], in_data};
            lcnt_d = lcnt_q + 4'd1;
          end
        end
        S_SP2:  state_d = (in_data == " ") ? S_OPEN : S_TEXT;
        S_OPEN: state_d = (in_data == "(") ? S_AT : S_TEXT;
        S_AT:   state_d = (in_data == "@") ? S_SP3 : S_TEXT;
        S_SP3:  state_d = (in_data == " ") ? S_DIGITS : S_TEXT;
        S_DIGITS: begin
          if (is_digit) begin
            ndig_d = 1'b1;
            // saturated value stays saturated: all-ones*10 always overflows
            if (t_ext > TW'({TS_WIDTH{1'b1}})) begin
              time_d = '1;
              ovf_d  = 1'b1;
            end else begin
              time_d = t_ext[TS_WIDTH-1:0];
            end
          end else begin
            ok_d    = (in_data == ")") && ndig_q;
            state_d = S_TEXT;
          end
        end
        S_TEXT:  state_d = S_TEXT;
        default: state_d = S_MODNAME;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_MODNAME;
      lvl_q       <= 3'd0;
      ok_q        <= 1'b0;
      time_q      <= '0;
      ovf_q       <= 1'b0;
      ndig_q      <= 1'b0;
      lbuf_q      <= '0;
      lcnt_q      <= 4'd0;
      evt_valid_q <= 1'b0;
      evt_level_q <= 3'd0;
      evt_time_q  <= '0;
      evt_ovf_q   <= 1'b0;
      line_cnt_q  <= 16'd0;
      drop_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      ok_q        <= ok_d;
      time_q      <= time_d;
      ovf_q       <= ovf_d;
      ndig_q      <= ndig_d;
      lbuf_q      <= lbuf_d;
      lcnt_q      <= lcnt_d;
      evt_valid_q <= evt_valid_d;
      evt_level_q <= evt_level_d;
      evt_time_q  <= evt_time_d;
      evt_ovf_q   <= evt_ovf_d;
      line_cnt_q  <= line_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_svl_line_decoder.sv
// Directed bench for svl_line_decoder: parsing, filter, overflow,
// backpressure and mid-line reset.
module tb_svl_line_decoder;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        evt_valid;
  logic        evt_ready;
  logic [2:0]  evt_level;
  logic [31:0] evt_time;
  logic        evt_time_ovf;
  logic [15:0] line_count;
  logic [15:0] drop_count;
  logic        rdy_en;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  lvl;
    logic [31:0] t;
    logic        ovf;
  } evt_t;

  evt_t evq[$];

  svl_line_decoder #(.VERBOSITY(2), .TS_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_level    (evt_level),
    .evt_time     (evt_time),
    .evt_time_ovf (evt_time_ovf),
    .line_count   (line_count),
    .drop_count   (drop_count)
  );

  assign evt_ready = rdy_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && evt_valid && evt_ready)
      evq.push_back('{evt_level, evt_time, evt_time_ovf});
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 200) begin
        chk("send_timeout", 64'(n), 64'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input string tag, input logic [2:0] l,
                            input logic [31:0] t, input logic o);
    evt_t e;
    chk({tag, "_present"}, 64'(evq.size() > 0), 64'd1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      chk({tag, "_lvl"}, 64'(e.lvl), 64'(l));
      chk({tag, "_time"}, 64'(e.t), 64'(t));
      chk({tag, "_ovf"}, 64'(e.ovf), 64'(o));
    end
  endtask

  initial begin
    int low_cnt;
    int w;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    rdy_en   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_evt_valid", 64'(evt_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_level", 64'(evt_level), 64'd0);
    chk("rst_time", 64'(evt_time), 64'd0);
    chk("rst_ovf", 64'(evt_time_ovf), 64'd0);
    chk("rst_lines", 64'(line_count), 64'd0);
    chk("rst_drops", 64'(drop_count), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send_str("top: INFO: (@ 1250) ok");
    chk("info_pre_valid", 64'(evt_valid), 64'd0);
    send_byte(8'h0A);
    chk("info_lat_valid", 64'(evt_valid), 64'd1);
    chk("info_lat_level", 64'(evt_level), 64'd2);
    settle();
    expect_evt("info", 3'd2, 32'd1250, 1'b0);
    chk("info_lines", 64'(line_count), 64'd1);

    send_str("top: DEBUG: (@ 7) x\n");
    settle();
    chk("dbg_noevt", 64'(evq.size()), 64'd0);
    chk("dbg_drops", 64'(drop_count), 64'd1);
    chk("dbg_lines", 64'(line_count), 64'd2);

    send_str("hello\n\n");
    settle();
    expect_evt("hello", 3'd0, 32'd0, 1'b0);
    expect_evt("empty", 3'd0, 32'd0, 1'b0);

    send_str("m: ERROR: (@ 99999999999) e\n");
    settle();
    expect_evt("err_ovf", 3'd5, 32'hFFFF_FFFF, 1'b1);

    send_str("m: INFOX: (@ 5) a\nm: WARNING: (@ ) b\n");
    settle();
    expect_evt("infox", 3'd0, 32'd0, 1'b0);
    expect_evt("nodig", 3'd0, 32'd0, 1'b0);

    send_str("z: CRITICAL: (@ 42) c\r\n");
    settle();
    expect_evt("crit", 3'd4, 32'd42, 1'b0);
    chk("lines8", 64'(line_count), 64'd8);
    chk("drops1", 64'(drop_count), 64'd1);

    rdy_en = 1'b0;
    low_cnt = 0;
    fork
      begin
        send_str("a: INFO: (@ 3) x\n");
        send_str("b: IN\rFO: (@ 4) y\r\n");
      end
      begin
        w = 0;
        while (!evt_valid && w < 500) begin
          @(negedge clk);
          w++;
        end
        chk("bp_first_seen", 64'(evt_valid), 64'd1);
        repeat (20) begin
          @(negedge clk);
          if (!in_ready && evt_valid) low_cnt++;
        end
        @(posedge clk);
        #1;
        rdy_en = 1'b1;
      end
    join
    settle();
    chk("bp_in_ready_low", 64'(low_cnt), 64'd20);
    expect_evt("bp_first", 3'd2, 32'd3, 1'b0);
    expect_evt("bp_second", 3'd2, 32'd4, 1'b0);
    chk("bp_lines", 64'(line_count), 64'd10);

    send_str("c: INFO: (@ 12");
    rst = 1'b1;
    #1;
    chk("mid_rst_lines", 64'(line_count), 64'd0);
    chk("mid_rst_valid", 64'(evt_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    settle();
    chk("mid_rst_noevt", 64'(evq.size()), 64'd0);
    chk("mid_rst_drops", 64'(drop_count), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);

    send_str("q: WARNING: (@ 5) w\n");
    settle();
    expect_evt("post_rst", 3'd3, 32'd5, 1'b0);
    chk("post_rst_lines", 64'(line_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/svl_line_decoder.md
SVL_LINE_DECODER -- requirements
Module: svl_line_decoder

Interface
REQ-001 SHALL have parameter VERBOSITY, default 2; filter threshold (0 off, 1 DEBUG .. 5 ERROR).
REQ-002 SHALL have parameter TS_WIDTH, default 32; timestamp field width.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_data  in  8  ASCII byte of a log text stream.
REQ-006 SHALL have port in_valid  in  1  in_data valid.
REQ-007 SHALL have port in_ready  out  1  byte accepted when in_valid && in_ready.
REQ-008 SHALL have port evt_valid  out  1  decoded line event pending.
REQ-009 SHALL have port evt_ready  in  1  consumer accepts event.
REQ-010 SHALL have port evt_level  out  3  0 MSG, 1 DEBUG, 2 INFO, 3 WARNING, 4 CRITICAL, 5 ERROR.
REQ-011 SHALL have port evt_time  out  TS_WIDTH  decoded "(@ t)" value.
REQ-012 SHALL have port evt_time_ovf  out  1  timestamp saturated.
REQ-013 SHALL have port line_count  out  16  lines terminated, saturating.
REQ-014 SHALL have port drop_count  out  16  lines filtered out, saturating.

Function
REQ-015 SHALL parse lines of form "<module>: <LEVEL>: (@ <decimal>) <text>" ending in 0x0A; 0x0D SHALL be ignored everywhere.
REQ-016 SHALL use FSM states MODNAME, SP1, LEVEL, SP2, OPEN, AT, SP3, DIGITS, TEXT, EMIT.
REQ-017 MODNAME: consume bytes until ':' -> SP1; SP1 requires ' ' -> LEVEL.
REQ-018 LEVEL: buffer up to 8 chars until ':'; token SHALL match exactly "DEBUG","INFO","WARNING","CRITICAL","ERROR" (case-sensitive) -> SP2; a 9th char or no match -> TEXT with level 0.
REQ-019 SP2/OPEN/AT/SP3 SHALL require ' ', '(', '@', ' ' in order; mismatch -> TEXT with level 0, time 0.
REQ-020 DIGITS: each '0'-'9' SHALL update t = t*10 + d; ')' with >=1 digit -> TEXT; ')' with zero digits or any other char -> TEXT with level 0, time 0.
REQ-021 Timestamp arithmetic SHALL be done at TS_WIDTH+4 bits; on exceeding 2^TS_WIDTH-1 evt_time SHALL saturate to all-ones and evt_time_ovf SHALL set for that line.
REQ-022 TEXT SHALL discard bytes until 0x0A; unbounded text length.
REQ-023 0x0A in any state SHALL terminate the line; if the level was not fully validated the line SHALL be reported as level 0, time 0 (plain msg, including empty lines).
REQ-024 Filter: line emitted iff level==0, or VERBOSITY!=0 and level>=VERBOSITY; otherwise drop_count increments and no event.
REQ-025 Line termination SHALL increment line_count; evt_valid SHALL assert the cycle after the 0x0A handshake (latency 1).
REQ-026 evt_valid, evt_level, evt_time, evt_time_ovf SHALL hold stable until evt_valid && evt_ready.
REQ-027 in_ready SHALL equal !(evt_valid && !evt_ready); no byte lost or duplicated under backpressure.
REQ-028 Event accept and next byte accept in the same cycle SHALL both take effect.
REQ-029 Per-line level/time/ovf registers SHALL clear at start of each new line.
REQ-030 Counters SHALL saturate at 16'hFFFF.

Reset
REQ-031 reset SHALL asynchronously force FSM to MODNAME, evt_valid=0, evt_level=0, evt_time=0, evt_time_ovf=0, line_count=0, drop_count=0, in_ready=1.
REQ-032 Reset mid-line SHALL discard the partial line with no event and no count.

Verification
REQ-033 "top: INFO: (@ 1250) ok\n", VERBOSITY=2 -> one event level 2, time 1250, ovf 0; line_count 1.
REQ-034 "top: DEBUG: (@ 7) x\n", VERBOSITY=2 -> no event; drop_count 1, line_count 1.
REQ-035 "hello\n" and "\n" -> two events level 0, time 0.
REQ-036 "m: ERROR: (@ 99999999999) e\n", TS_WIDTH=32 -> level 5, time 32'hFFFFFFFF, ovf 1.
REQ-037 "m: INFOX: (@ 5) a\n" and "m: WARNING: (@ ) b\n" -> two events level 0, time 0.
REQ-038 Two INFO lines back-to-back, evt_ready held low 20 cycles -> in_ready low while first event pending, both events delivered in order; reset asserted mid-third line -> no third event, counters 0.
